dmem_ctrl: RTL and testbench

//  Data-memory controller directly downstream of the load/store unit. Takes one LSU access (op, byte address, store data)
//  per valid/ready handshake and drives a word-wide single-port synchronous RAM.

---
 rtl/dmem_ctrl_pkg.sv | 47 ++++
 rtl/dmem_lane_merge.sv | 48 ++++
 rtl/dmem_ctrl.sv | 149 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared LSU op encodings, controller state encoding and op decode helpers.
// The decode lives here so the LSU and the memory controller cannot disagree.
package dmem_ctrl_pkg;

    localparam logic [2:0] LSU_LB  = 3'd0;
    localparam logic [2:0] LSU_LH  = 3'd1;
    localparam logic [2:0] LSU_LW  = 3'd2;
    localparam logic [2:0] LSU_LBU = 3'd3;
    localparam logic [2:0] LSU_LHU = 3'd4;
    localparam logic [2:0] LSU_SB  = 3'd5;
    localparam logic [2:0] LSU_SH  = 3'd6;
    localparam logic [2:0] LSU_SW  = 3'd7;

    typedef enum logic [2:0] {
        DMEM_IDLE = 3'd0,
        DMEM_RD   = 3'd1,
        DMEM_CAP  = 3'd2,
        DMEM_WR   = 3'd3,
        DMEM_RESP = 3'd4
    } dmem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } dmem_size_e;

    function automatic logic is_load(input logic [2:0] op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic dmem_size_e op_size(input logic [2:0] op);
        dmem_size_e sz;
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: sz = SZ_BYTE;
            LSU_LH, LSU_LHU, LSU_SH: sz = SZ_HALF;
            default:                 sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte-lane helper for the data-memory controller: merges store data into an
// old RAM word and right-aligns load data out of a RAM word.
module dmem_lane_merge
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  off_i,
    input  dmem_size_e  size_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [31:0] shifted;

    // Replace only the addressed lanes; a full word store takes the data as-is.
    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SZ_BYTE: begin
                case (off_i)
                    2'd0:    merged_o[7:0]   = data_i[7:0];
                    2'd1:    merged_o[15:8]  = data_i[7:0];
                    2'd2:    merged_o[23:16] = data_i[7:0];
                    default: merged_o[31:24] = data_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off_i[1]) merged_o[31:16] = data_i[15:0];
                else          merged_o[15:0]  = data_i[15:0];
            end
            default: merged_o = data_i;
        endcase
    end

    assign shifted = old_word_i >> {off_i, 3'b000};

    // Zero-filled load result; the LSU does any sign extension.
    always_comb begin
        load_o = shifted;
        case (size_i)
            SZ_BYTE: load_o = {24'h0, shifted[7:0]};
            SZ_HALF: load_o = {16'h0, shifted[15:0]};
            default: load_o = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the LSU and a word-wide single-port
// synchronous RAM. One access in flight; byte/half stores are read-modify-write.
//
//   state | meaning
//   IDLE  | ready for a request
//   RD    | RAM read of the latched word (RMW or load)
//   CAP   | capture RAM read data
//   WR    | RAM write of the merged / full word
//   RESP  | one-cycle response pulse
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    dmem_state_e       state_q, state_d;
    logic [2:0]        op_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] word_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       old_q;

    logic [32:0]       diff;
    logic [31:0]       rel;
    logic              below_base;
    logic              above_top;
    logic              misaligned;
    logic              req_err;
    logic              accept;
    logic [1:0]        req_off;
    dmem_size_e        req_size;
    logic [31:0]       merged_word;
    logic [31:0]       load_word;

    // Borrow out of the 33-bit subtraction means the address is below the base.
    assign diff       = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign below_base = diff[32];
    assign rel        = diff[31:0];
    assign above_top  = |rel[31:ADDR_W+2];
    // Base is word aligned, so the offset within the word survives the subtraction.
    assign req_off    = rel[1:0];
    assign req_size   = op_size(req_op);
    assign misaligned = ((req_size == SZ_HALF) && req_off[0]) ||
                        ((req_size == SZ_WORD) && (req_off != 2'b00));
    assign req_err    = misaligned | below_base | above_top;
    assign accept     = req_valid & req_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= DMEM_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DMEM_IDLE: begin
                if (req_valid) begin
                    if (req_err)               state_d = DMEM_RESP;
                    else if (req_op == LSU_SW) state_d = DMEM_WR;
                    else                       state_d = DMEM_RD;
                end
            end
            DMEM_RD:   state_d = DMEM_CAP;
            DMEM_CAP:  state_d = is_store(op_q) ? DMEM_WR : DMEM_RESP;
            DMEM_WR:   state_d = DMEM_RESP;
            DMEM_RESP: state_d = DMEM_IDLE;
            default:   state_d = DMEM_IDLE;
        endcase
    end

    // Request latch at accept and read-data capture in CAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= LSU_LB;
            off_q   <= 2'b00;
            word_q  <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            old_q   <= 32'h0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                off_q   <= req_off;
                word_q  <= rel[ADDR_W+1:2];
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (state_q == DMEM_CAP) old_q <= ram_rdata;
        end
    end

    dmem_lane_merge u_lane_merge (
        .old_word_i (old_q),
        .data_i     (wdata_q),
        .off_i      (off_q),
        .size_i     (op_size(op_q)),
        .merged_o   (merged_word),
        .load_o     (load_word)
    );

    assign ram_addr = word_q;

    // Output decode from the current state.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'h0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = 32'h0;
        case (state_q)
            DMEM_IDLE: req_ready = 1'b1;
            DMEM_RD:   ram_en    = 1'b1;
            DMEM_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = merged_word;
            end
            DMEM_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!err_q && is_load(op_q)) rsp_rdata = load_word;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a reference model of memory semantics
// and a per-cycle response checker.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int          ADDR_W = 10;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_op = 3'd0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // 1-cycle-latency synchronous RAM with access counters.
    logic [31:0] ram [DEPTH];
    int rd_cnt = 0, wr_cnt = 0, en_cnt = 0;
    always @(posedge clk) begin
        if (ram_en) begin
            en_cnt <= en_cnt + 1;
            if (ram_we) begin
                ram[ram_addr] <= ram_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                ram_rdata <= ram[ram_addr];
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] gold [DEPTH];

    function automatic int op_bytes(input logic [2:0] op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: return 1;
            LSU_LH, LSU_LHU, LSU_SH: return 2;
            default:                 return 4;
        endcase
    endfunction

    function automatic bit op_writes(input logic [2:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    bit              mon_on = 1'b0;
    int              ncyc = 0;
    bit              pend = 1'b0;
    int              due = 0;
    bit              m_err, m_store, exp_v;
    int              m_nb, m_word, m_off, m_lat;
    logic [31:0]     m_rdata, m_data, m_mask, w;
    longint unsigned a_l, base_l, rel_l;
    int              last_resp = -1;
    int              acc_cyc = 0, acc_prev = 0;
    int              obs_lat = 0;
    logic [31:0]     obs_rdata = 32'h0;
    logic            obs_err = 1'b0;

    function automatic void commit_store();
        logic [31:0] cw;
        cw = gold[m_word];
        for (int i = 0; i < m_nb; i++) cw[8*(m_off+i) +: 8] = m_data[8*i +: 8];
        gold[m_word] = cw;
    endfunction

    // Per-cycle checker; accepts are predicted from the handshake seen mid-cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            ncyc++;
            exp_v = pend && (ncyc == due);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            chk("req_ready", 32'(req_ready), 32'(!pend && (ncyc > last_resp)));
            if (pend && m_err) chk("err_ram_en", 32'(ram_en), 32'd0);
            if (rsp_valid) begin
                obs_lat   = ncyc - acc_cyc;
                obs_rdata = rsp_rdata;
                obs_err   = rsp_err;
            end
            if (exp_v) begin
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
                chk("rsp_rdata", rsp_rdata, m_rdata);
                if (m_store && !m_err) commit_store();
                pend = 1'b0;
                last_resp = ncyc;
            end
            if (!rst_n) begin
                // A write whose RAM cycle meets the reset edge still lands.
                if (pend && m_store && !m_err && (m_nb != 4 || 1) && ncyc == due - 1) commit_store();
                pend = 1'b0;
            end else if (req_valid && req_ready) begin
                a_l     = req_addr;
                base_l  = BASE;
                m_nb    = op_bytes(req_op);
                m_store = op_writes(req_op);
                m_data  = req_wdata;
                m_off   = int'(a_l % 4);
                rel_l   = a_l - base_l;
                m_err   = (a_l % m_nb != 0) || (a_l < base_l) || ((rel_l / 4) >= DEPTH);
                m_word  = m_err ? 0 : int'(rel_l / 4);
                m_rdata = 32'h0;
                if (m_err)        m_lat = 1;
                else if (m_store) m_lat = (m_nb == 4) ? 2 : 4;
                else begin
                    m_lat   = 3;
                    m_mask  = (m_nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*m_nb)) - 32'd1);
                    w       = gold[m_word];
                    m_rdata = (w >> (8*m_off)) & m_mask;
                end
                pend     = 1'b1;
                due      = ncyc + m_lat;
                acc_prev = acc_cyc;
                acc_cyc  = ncyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic preload(input int idx, input logic [31:0] val);
        ram[idx] <= val;
        gold[idx] = val;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input bit wait_done);
        int n = 0;
        bit ok;
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        do begin
            ok = req_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 40);
        req_valid = 1'b0;
        chk("accept_timeout", 32'(ok), 32'd1);
        if (wait_done) wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int r0, w0, e0, mism;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] <= 32'h0;
            gold[i] = 32'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'd0);
        chk("rst_ram_en",    32'(ram_en),    32'd0);
        chk("rst_ram_we",    32'(ram_we),    32'd0);
        chk("rst_ram_addr",  32'(ram_addr),  32'd0);
        chk("rst_ram_wdata", ram_wdata,      32'd0);
        rst_n = 1'b1;
        mon_on = 1'b1;
        @(posedge clk); #1;

        // Word load
        preload(4, 32'hDEAD_BEEF);
        do_req(LSU_LW, 32'h10, 32'h0, 1'b1);
        chk("lw_rdata", obs_rdata, 32'hDEAD_BEEF);
        chk("lw_err", 32'(obs_err), 32'd0);
        chk("lw_lat", 32'(obs_lat), 32'd3);

        // Byte store read-modify-write
        preload(4, 32'h1122_3344);
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(LSU_SB, 32'h13, 32'h0000_00AA, 1'b1);
        chk("sb_ram", ram[4], 32'hAA22_3344);
        chk("sb_reads", 32'(rd_cnt - r0), 32'd1);
        chk("sb_writes", 32'(wr_cnt - w0), 32'd1);
        chk("sb_lat", 32'(obs_lat), 32'd4);
        chk("sb_rdata", obs_rdata, 32'd0);

        // Half store then half load
        preload(4, 32'h1122_3344);
        do_req(LSU_SH, 32'h12, 32'h0000_BEEF, 1'b1);
        chk("sh_ram", ram[4], 32'hBEEF_3344);
        do_req(LSU_LHU, 32'h12, 32'h0, 1'b1);
        chk("lhu_rdata", obs_rdata, 32'h0000_BEEF);

        // Sub-word loads from other lanes
        do_req(LSU_LB, 32'h11, 32'h0, 1'b1);
        chk("lb_rdata", obs_rdata, 32'h0000_0033);
        do_req(LSU_LH, 32'h10, 32'h0, 1'b1);
        chk("lh_rdata", obs_rdata, 32'h0000_3344);
        do_req(LSU_LBU, 32'h13, 32'h0, 1'b1);
        chk("lbu_rdata", obs_rdata, 32'h0000_00BE);

        // Errors: misaligned and out-of-range, no RAM activity
        e0 = en_cnt;
        do_req(LSU_LW, 32'h0E, 32'h0, 1'b1);
        chk("lw_mis_err", 32'(obs_err), 32'd1);
        chk("lw_mis_lat", 32'(obs_lat), 32'd1);
        do_req(LSU_SH, 32'h11, 32'h1234, 1'b1);
        chk("sh_mis_err", 32'(obs_err), 32'd1);
        do_req(LSU_LW, 32'h1000, 32'h0, 1'b1);
        chk("lw_oor_err", 32'(obs_err), 32'd1);
        chk("lw_oor_rdata", obs_rdata, 32'd0);
        chk("err_no_access", 32'(en_cnt - e0), 32'd0);
        chk("err_ram_same", ram[4], 32'hBEEF_3344);

        // Last in-range word
        preload(1023, 32'hCAFE_F00D);
        do_req(LSU_LW, 32'hFFC, 32'h0, 1'b1);
        chk("lw_top_rdata", obs_rdata, 32'hCAFE_F00D);
        chk("lw_top_err", 32'(obs_err), 32'd0);

        // Reset while an SB sits in CAP
        w0 = wr_cnt;
        do_req(LSU_SB, 32'h13, 32'h0000_0055, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        chk("rstmid_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rstmid_ram", ram[4], 32'hBEEF_3344);
        chk("rstmid_writes", 32'(wr_cnt - w0), 32'd0);

        // Back-to-back SW then LW with valid held
        do_req(LSU_SW, 32'h20, 32'h1234_5678, 1'b0);
        do_req(LSU_LW, 32'h20, 32'h0, 1'b1);
        chk("b2b_gap", 32'(acc_cyc - acc_prev), 32'd3);
        chk("b2b_rdata", obs_rdata, 32'h1234_5678);
        chk("sw_ram", ram[8], 32'h1234_5678);

        repeat (3) @(posedge clk);
        #1;
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== gold[i]) mism++;
        chk("mem_image_mismatches", 32'(mism), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
